// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM states, RISC-V
// load/store funct3 encodings and the access alignment rule.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      DONE  = 2'b11
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Encodings outside the five legal widths are rejected like a misaligned access.
   function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] lane);
      logic bad;
      case (func3)
         F3_B, F3_BU: bad = 1'b0;
         F3_H, F3_HU: bad = lane[0];
         F3_W:        bad = (lane != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Bundle of EX/MEM request, data-cache and writeback signals around the LSU.
// slave = the LSU itself, master = the surrounding pipeline/cache.
interface mem_stage_lsu_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_is_store;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [2:0]        req_func3;
   logic [4:0]        req_rd;
   logic [ADDR_W-1:0] cache_addr;
   logic [31:0]       cache_wdata;
   logic              cache_we;
   logic [2:0]        cache_func3;
   logic [31:0]       cache_rdata;
   logic              cache_hit;
   logic              cache_busy;
   logic              stall;
   logic              wb_valid;
   logic [31:0]       wb_data;
   logic [4:0]        wb_rd;
   logic              misaligned;
   logic              timeout_err;

   modport slave (
      input  req_valid, req_is_store, req_addr, req_wdata, req_func3, req_rd,
      input  cache_rdata, cache_hit, cache_busy,
      output cache_addr, cache_wdata, cache_we, cache_func3,
      output stall, wb_valid, wb_data, wb_rd, misaligned, timeout_err
   );

   modport master (
      output req_valid, req_is_store, req_addr, req_wdata, req_func3, req_rd,
      output cache_rdata, cache_hit, cache_busy,
      input  cache_addr, cache_wdata, cache_we, cache_func3,
      input  stall, wb_valid, wb_data, wb_rd, misaligned, timeout_err
   );

endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half/word lane out of a raw 32-bit read word and
// sign- or zero-extends it according to funct3. Purely combinational.
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  func3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select then extension.
   always_comb begin
      byte_s = rdata_i[{lane_i, 3'b000} +: 8];
      half_s = rdata_i[{lane_i[1], 4'b0000} +: 16];
      case (func3_i)
         F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
         F3_BU:   data_o = {24'h000000, byte_s};
         F3_H:    data_o = {{16{half_s[15]}}, half_s};
         F3_HU:   data_o = {16'h0000, half_s};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one access to the data cache, stalls the
// pipeline until it completes, and returns extended load data to writeback.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 20,
   parameter int ADDR_W  = 32
) (
   input logic clk,
   input logic reset,
   mem_stage_lsu_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        func3_q;
   logic [4:0]        rd_q;
   logic              store_q;
   logic              we_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              wb_valid_q;
   logic [31:0]       wb_data_q;
   logic [4:0]        wb_rd_q;
   logic              misal_q;
   logic              tout_q;

   logic              misal_s;
   logic              accept_s;
   logic              done_s;
   logic              tout_s;
   logic [31:0]       align_s;

   load_align u_load_align (
      .rdata_i (bus.cache_rdata),
      .lane_i  (addr_q[1:0]),
      .func3_i (func3_q),
      .data_o  (align_s)
   );

   // Next-state and transaction events; busy outranks hit, completion outranks timeout.
   always_comb begin
      state_d  = state_q;
      accept_s = 1'b0;
      done_s   = 1'b0;
      tout_s   = 1'b0;
      misal_s  = is_misaligned(bus.req_func3, bus.req_addr[1:0]);
      case (state_q)
         IDLE: begin
            if (bus.req_valid && !misal_s) begin
               accept_s = 1'b1;
               state_d  = ISSUE;
            end else begin
               state_d  = IDLE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (!bus.cache_busy && (bus.cache_hit || store_q)) begin
               done_s  = 1'b1;
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               tout_s  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, request latches, wait counter and registered result/flag outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= 32'h00000000;
         func3_q    <= F3_W;
         rd_q       <= 5'd0;
         store_q    <= 1'b0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= 32'h00000000;
         wb_rd_q    <= 5'd0;
         misal_q    <= 1'b0;
         tout_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept_s) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            func3_q <= bus.req_func3;
            rd_q    <= bus.req_rd;
            store_q <= bus.req_is_store;
            we_q    <= bus.req_is_store;
         end else if (done_s || tout_s) begin
            we_q <= 1'b0;
         end
         if (state_q == ISSUE) begin
            cnt_q <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         wb_valid_q <= done_s && !store_q;
         if (done_s && !store_q) begin
            wb_data_q <= align_s;
            wb_rd_q   <= rd_q;
         end
         misal_q <= (state_q == IDLE) && bus.req_valid && misal_s;
         if (tout_s) begin
            tout_q <= 1'b1;
         end
      end
   end

   assign bus.cache_addr  = addr_q;
   assign bus.cache_wdata = wdata_q;
   assign bus.cache_func3 = func3_q;
   assign bus.cache_we    = we_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.wb_rd       = wb_rd_q;
   assign bus.misaligned  = misal_q;
   assign bus.timeout_err = tout_q;
   // Stall must rise in the accepting cycle, so it cannot wait for a register.
   assign bus.stall = ((state_q == IDLE) && bus.req_valid && !misal_s)
                    || (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: transaction-level reference model
// producing per-cycle expectations, one compare process, directed + random ops.
module tb_mem_stage_lsu;
   import lsu_pkg::*;

   localparam int TIMEOUT = 20;
   localparam int ADDR_W  = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_stage_lsu_if #(.ADDR_W(ADDR_W)) bus ();

   mem_stage_lsu #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   logic        exp_stall, exp_we, exp_wb_valid, exp_misal, exp_tout;
   logic [31:0] exp_addr, exp_wdata, exp_wb_data;
   logic [2:0]  exp_func3;
   logic [4:0]  exp_wb_rd;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit rule_misaligned(input logic [2:0] f3, input logic [31:0] a);
      int size;
      case (f3)
         F3_B, F3_BU: size = 1;
         F3_H, F3_HU: size = 2;
         F3_W:        size = 4;
         default:     return 1'b1;
      endcase
      return (a % size) != 0;
   endfunction

   function automatic logic [31:0] rule_extract(input logic [2:0] f3, input logic [31:0] a,
                                                 input logic [31:0] w);
      int lane;
      longint v;
      lane = int'(a % 4);
      case (f3)
         F3_B, F3_BU: begin
            v = longint'((w >> (8 * lane)) & 32'hFF);
            if (f3 == F3_B && v >= 128) v = v - 256;
         end
         F3_H, F3_HU: begin
            v = longint'((w >> (16 * (lane / 2))) & 32'hFFFF);
            if (f3 == F3_H && v >= 32768) v = v - 65536;
         end
         default: v = longint'(w);
      endcase
      return v[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reset_exp();
      exp_stall = 1'b0; exp_we = 1'b0; exp_wb_valid = 1'b0; exp_misal = 1'b0;
      exp_tout = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_func3 = 3'b010;
      exp_wb_data = 32'h0; exp_wb_rd = 5'd0;
   endtask

   // Every cycle with checking enabled: DUT outputs vs the model's expectations.
   always @(negedge clk) begin
      if (check_en) begin
         check32("stall", 32'(bus.stall), 32'(exp_stall));
         check32("cache_we", 32'(bus.cache_we), 32'(exp_we));
         check32("cache_addr", bus.cache_addr, exp_addr);
         check32("cache_wdata", bus.cache_wdata, exp_wdata);
         check32("cache_func3", 32'(bus.cache_func3), 32'(exp_func3));
         check32("wb_valid", 32'(bus.wb_valid), 32'(exp_wb_valid));
         check32("misaligned", 32'(bus.misaligned), 32'(exp_misal));
         check32("timeout_err", 32'(bus.timeout_err), 32'(exp_tout));
         if (exp_wb_valid) begin
            check32("wb_data", bus.wb_data, exp_wb_data);
            check32("wb_rd", 32'(bus.wb_rd), 32'(exp_wb_rd));
         end
      end
   end

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      exp_stall = 1'b0; exp_wb_valid = 1'b0; exp_misal = 1'b0; exp_we = 1'b0;
      repeat (n) tick();
   endtask

   task automatic apply_reset();
      bus.req_valid = 1'b0;
      reset = 1'b0;
      check_en = 1'b0;
      tick();
      set_reset_exp();
      check_en = 1'b1;
      bus.cache_busy = 1'b0;
      bus.cache_hit  = 1'b1;
      tick();
      reset = 1'b1;
   endtask

   // One transaction from the IDLE cycle; returns with the pipeline back in IDLE.
   task automatic do_op(input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [4:0] rd, input int nbusy,
                        input bit rd_fixed, input logic [31:0] rdv, input int abort_at,
                        output logic [31:0] got);
      bit done;
      bit comp;
      logic [31:0] sampled;
      got = 32'h0;
      done = 1'b0;
      sampled = 32'h0;
      bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_addr = a;
      bus.req_wdata = wd; bus.req_func3 = f3; bus.req_rd = rd;
      bus.cache_busy = 1'b0; bus.cache_hit = 1'b0; bus.cache_rdata = $urandom;
      exp_wb_valid = 1'b0; exp_misal = 1'b0; exp_we = 1'b0;
      if (rule_misaligned(f3, a)) begin
         exp_stall = 1'b0;
         tick();
         bus.req_valid = 1'b0; bus.req_addr = $urandom;
         exp_misal = 1'b1;
         tick();
         exp_misal = 1'b0;
         return;
      end
      exp_stall = 1'b1;
      tick();
      bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
      bus.req_func3 = 3'($urandom); bus.req_rd = 5'($urandom); bus.req_is_store = 1'($urandom);
      exp_addr = a; exp_wdata = wd; exp_func3 = f3; exp_we = st;
      tick();
      for (int k = 0; k < TIMEOUT && !done; k++) begin
         if (k == abort_at) begin
            apply_reset();
            return;
         end
         if (k < nbusy) begin
            if (st) begin
               bus.cache_busy = 1'b1; bus.cache_hit = 1'($urandom);
            end else begin
               case ($urandom_range(0, 2))
                  0:       begin bus.cache_busy = 1'b1; bus.cache_hit = 1'b0; end
                  1:       begin bus.cache_busy = 1'b1; bus.cache_hit = 1'b1; end
                  default: begin bus.cache_busy = 1'b0; bus.cache_hit = 1'b0; end
               endcase
            end
         end else begin
            bus.cache_busy = 1'b0;
            bus.cache_hit = st ? 1'($urandom) : 1'b1;
         end
         bus.cache_rdata = rd_fixed ? rdv : 32'($urandom);
         comp = !bus.cache_busy && (bus.cache_hit || st);
         sampled = bus.cache_rdata;
         tick();
         done = comp;
      end
      bus.cache_busy = 1'b0; bus.cache_hit = 1'b0; bus.cache_rdata = $urandom;
      exp_stall = 1'b0; exp_we = 1'b0;
      if (!done) begin
         exp_tout = 1'b1;
         return;
      end
      exp_wb_valid = !st;
      exp_wb_data = rule_extract(f3, a, sampled);
      exp_wb_rd = rd;
      @(negedge clk);
      got = bus.wb_data;
      tick();
      exp_wb_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] got;
      bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0; bus.req_func3 = 3'b000; bus.req_rd = 5'd0;
      bus.cache_rdata = 32'h0; bus.cache_hit = 1'b0; bus.cache_busy = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      set_reset_exp();
      check_en = 1'b1;
      tick();
      reset = 1'b1;
      tick();

      do_op(1'b1, 32'h10, 32'h11111111, F3_W, 5'd0, 0, 1'b0, 32'h0, -1, got);
      idle(2);
      do_op(1'b0, 32'h10, 32'h0, F3_W, 5'd9, 5, 1'b1, 32'h11111111, -1, got);
      check32("lw_after_busy", got, 32'h11111111);
      do_op(1'b0, 32'h103, 32'h0, F3_B, 5'd1, 0, 1'b1, 32'h80FF7F01, -1, got);
      check32("lb_0x103", got, 32'hFFFFFF80);
      do_op(1'b0, 32'h102, 32'h0, F3_BU, 5'd2, 1, 1'b1, 32'h80FF7F01, -1, got);
      check32("lbu_0x102", got, 32'h000000FF);
      do_op(1'b0, 32'h102, 32'h0, F3_H, 5'd3, 2, 1'b1, 32'h80FF7F01, -1, got);
      check32("lh_0x102", got, 32'hFFFF80FF);
      do_op(1'b0, 32'h102, 32'h0, F3_HU, 5'd4, 0, 1'b1, 32'h80FF7F01, -1, got);
      check32("lhu_0x102", got, 32'h000080FF);
      do_op(1'b0, 32'h106, 32'h0, F3_W, 5'd5, 0, 1'b0, 32'h0, -1, got);
      do_op(1'b0, 32'h101, 32'h0, F3_H, 5'd6, 0, 1'b0, 32'h0, -1, got);
      do_op(1'b0, 32'h100, 32'h0, 3'b011, 5'd6, 0, 1'b0, 32'h0, -1, got);
      do_op(1'b0, 32'h200, 32'h0, F3_W, 5'd8, TIMEOUT - 1, 1'b1, 32'hCAFEF00D, -1, got);
      check32("lw_last_chance", got, 32'hCAFEF00D);
      do_op(1'b0, 32'h300, 32'h0, F3_W, 5'd10, 1000, 1'b0, 32'h0, -1, got);
      idle(3);
      check32("timeout_sticky", 32'(bus.timeout_err), 32'd1);
      do_op(1'b0, 32'h304, 32'h0, F3_W, 5'd11, 0, 1'b1, 32'h12345678, -1, got);
      check32("lw_after_timeout", got, 32'h12345678);
      apply_reset();
      idle(2);
      do_op(1'b0, 32'h400, 32'h0, F3_W, 5'd12, 1000, 1'b0, 32'h0, 4, got);
      idle(6);

      for (int i = 0; i < 300; i++) begin
         logic [2:0] f3;
         int nb;
         f3 = 3'($urandom);
         nb = ($urandom_range(0, 15) == 0) ? TIMEOUT + 2 : $urandom_range(0, 8);
         do_op(1'($urandom), $urandom, $urandom, f3, 5'($urandom), nb, 1'b0, 32'h0,
               ($urandom_range(0, 40) == 0) ? 2 : -1, got);
         idle($urandom_range(0, 2));
         if ($urandom_range(0, 60) == 0) apply_reset();
      end

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit in the pipeline MEM stage, directly upstream of the data cache. It accepts one load/store per transaction from the EX/MEM register and drives the cache request lines.
- Holds the address stable and stalls the pipeline while the cache is busy or missing.
- Returns a lane-selected, sign- or zero-extended load result, with rd, to the writeback stage.
- Flags misaligned accesses and hung transactions.

Parameters:
- TIMEOUT, 20: max wait cycles per transaction before the error abort.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk.
- req_valid  in  1  EX/MEM holds a memory op.
- req_is_store  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, unshifted.
- req_func3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_rd  in  5  load destination register.
- cache_addr  out  ADDR_W  to cache addr.
- cache_wdata  out  32  to cache write_data.
- cache_we  out  1  to cache write_en.
- cache_func3  out  3  to cache func3.
- cache_rdata  in  32  cache read_data; raw word at addr[31:2].
- cache_hit  in  1  cache hit.
- cache_busy  in  1  cache refill/update in progress.
- stall  out  1  freeze IF/ID/EX/MEM registers.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_data  out  32  extended load data.
- wb_rd  out  5  load destination.
- misaligned  out  1  one-cycle pulse: misaligned access dropped.
- timeout_err  out  1  sticky until reset: a transaction exceeded TIMEOUT.

Behaviour:
- Reset values: state=IDLE, all outputs 0, cache_func3=010, internal latches 0. Reset mid-transaction abandons it immediately; no wb_valid is produced.
- Combinational alignment check:
  - H/HU is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]!=00.
  - Undefined func3 (011, 110, 111) is treated as misaligned.
- IDLE:
  - req_valid and misaligned: pulse misaligned next cycle, no cache access, stall=0, stay IDLE.
  - req_valid and aligned: latch addr, wdata, func3, rd, is_store; go to ISSUE. stall asserts combinationally in the same cycle.
- ISSUE (exactly 1 cycle):
  - Drive cache_addr/wdata/func3 from the latches; cache_we = is_store.
  - Clear the wait counter; go to WAIT. This gives the cache one cycle to register the request.
- WAIT:
  - Keep the cache outputs stable; cache_we stays high for the whole store transaction. Increment the counter.
  - Complete when cache_busy=0 and (cache_hit=1 or is_store=1): go to DONE.
  - Counter reaching TIMEOUT: set timeout_err, go to IDLE, no wb_valid.
- DONE (1 cycle):
  - cache_we drops to 0.
  - For loads: wb_valid=1, wb_rd=latched rd, wb_data from cache_rdata sampled at the WAIT->DONE transition.
  - stall deasserts in this cycle; go to IDLE.
  - A new req_valid is accepted only from IDLE, so the minimum aligned transaction is 4 cycles: IDLE, ISSUE, WAIT, DONE.
- stall = req_valid in IDLE with an aligned request, or state in {ISSUE, WAIT}.
- Load extraction, by latched addr[1:0] lane:
  - B: sign-extend byte[8*addr[1:0]+:8].
  - BU: zero-extend the same byte.
  - H: sign-extend half[16*addr[1]+:16].
  - HU: zero-extend the same half.
  - W: full word.
- Stores: req_wdata is passed unshifted with full addr and func3; byte-lane placement is the cache's responsibility. Stores never assert wb_valid.
- cache_addr is passed as the full byte address.
- Simultaneous cache_busy=1 and cache_hit=1: keep waiting; busy takes priority.

Decomposition:
- Shared package lsu_pkg holds:
  - state localparams: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, DONE=2'b11;
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One sub-module, load_align: purely combinational; inputs rdata, addr[1:0], func3; output extended data. It is also reused by a future uncached I/O path.

Test Plan:
- After reset release: store W 0x00000010 data 0x11111111 with the cache hitting immediately. Require stall high for 3 cycles, cache_we high through ISSUE+WAIT, no wb_valid, misaligned=0.
- Load W 0x00000010 with cache busy for 5 cycles, then hit with rdata 0x11111111. Require stall held throughout, cache_addr stable, then wb_valid=1 with wb_data=0x11111111 and the correct wb_rd.
- Load B, BU, H, HU at 0x103, 0x102, 0x102, 0x102 with cache rdata 0x80FF7F01. Require respectively:
  - B: 0xFFFFFF80;
  - BU: 0x000000FF;
  - H: 0xFFFF80FF;
  - HU: 0x000080FF.
- LW at 0x00000106 and LH at 0x00000101. Require a one-cycle misaligned pulse each, cache_we=0, cache_addr unchanged, stall=0, no wb_valid.
- Load with cache_busy held 1 forever. Require timeout_err set after TIMEOUT (20) WAIT cycles, return to IDLE, stall released, timeout_err remaining high until reset=0.
- Assert reset=0 during WAIT of a load. Require the next edge to show state IDLE, stall=0, wb_valid=0, with no completion after release.
